// File: rtl/uart_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_responder_pkg
// Description : Shared types and helpers for the UART bus responder: byte
//               type, TX/RX state encoding, bit-period counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bus_responder_pkg;

    typedef logic [7:0] uart_byte_t;

    // Shared by the TX and RX frame state machines.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Index of the last data bit (d7) in a frame.
    localparam logic [2:0] c_LAST_BIT = 3'd7;

    // Width of a counter that must reach DIV-1.
    function automatic int cnt_width(input int div);
        cnt_width = (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_responder_if
// Description : Parallel UART handshake between the CPU-side initiator and
//               the UART responder.
//   rdn        : read strobe, active-low (initiator -> responder)
//   wrn        : write strobe, active-low (initiator -> responder)
//   data_ready : received byte available (responder -> initiator)
//   tbre       : transmit holding register empty (responder -> initiator)
//   tsre       : transmit shift register empty (responder -> initiator)
//   The 8-bit tri-state data bus is a separate inout on the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_bus_responder_if;
    logic rdn;
    logic wrn;
    logic data_ready;
    logic tbre;
    logic tsre;

    modport master (
        output rdn,
        output wrn,
        input  data_ready,
        input  tbre,
        input  tsre
    );

    modport slave (
        input  rdn,
        input  wrn,
        output data_ready,
        output tbre,
        output tsre
    );
endinterface
`default_nettype wire

// File: rtl/uart_bus_responder_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_responder_rx_core
// Description : 8N1 receiver. Synchronizes rxd and rdn, runs the RX frame
//               FSM, holds the received byte and the data_ready/overrun
//               flags (cleared by a synchronized rdn rising edge).
//   clk, rst      : clock, asynchronous active-high reset
//   rxd_i         : serial input, idle high (asynchronous)
//   rdn_i         : raw read strobe, active-low (asynchronous)
//   rx_buf_o      : last accepted byte
//   data_ready_o  : byte waiting in rx_buf_o
//   overrun_o     : sticky, a byte was dropped while data_ready_o was set
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_responder_rx_core
    import uart_bus_responder_pkg::*;
#(
    parameter int DIV = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   rxd_i,
    input  wire logic   rdn_i,
    output uart_byte_t  rx_buf_o,
    output logic        data_ready_o,
    output logic        overrun_o
);
    localparam int               CNT_W       = cnt_width(DIV);
    localparam logic [CNT_W-1:0] c_DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(DIV / 2 - 1);

    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic rdn_s1_q, rdn_s2_q, rdn_prev_q;

    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    uart_byte_t       shift_q;
    uart_byte_t       buf_q;
    logic             ready_q;
    logic             overrun_q;

    logic w_rx_fall;
    logic w_rdn_rise;

    assign w_rx_fall  = ~rx_s2_q & rx_prev_q;
    assign w_rdn_rise = rdn_s2_q & ~rdn_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rdn_s1_q   <= 1'b1;
            rdn_s2_q   <= 1'b1;
            rdn_prev_q <= 1'b1;
        end else begin
            rx_s1_q    <= rxd_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rdn_s1_q   <= rdn_i;
            rdn_s2_q   <= rdn_s1_q;
            rdn_prev_q <= rdn_s2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            buf_q     <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Read acknowledge first, so a frame completing in the same
            // cycle still lands in the buffer without raising overrun.
            if (w_rdn_rise) begin
                ready_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_rx_fall) begin
                        // The detection cycle already counts towards the
                        // half-bit wait, keeping samples centred relative to
                        // the synchronized edge.
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == c_HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        // Line back high at mid start bit: glitch, not a frame.
                        state_q <= rx_s2_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == c_DIV_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                        if (bit_q == c_LAST_BIT) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == c_DIV_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        // Stop bit low is a framing error: silently dropped.
                        if (rx_s2_q) begin
                            if (ready_q && !w_rdn_rise) begin
                                overrun_q <= 1'b1;
                            end else begin
                                buf_q   <= shift_q;
                                ready_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_buf_o     = buf_q;
    assign data_ready_o = ready_q;
    assign overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: rtl/uart_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_responder
// Description : Stand-in for the external UART chip: responder side of the
//               CPU's parallel UART handshake, with an 8N1 serializer and
//               deserializer at DIV = CLK_HZ/BAUD clocks per bit.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : rdn/wrn strobes in, data_ready/tbre/tsre status out
//   data_io    : shared data bus, driven with rx_buf only while rdn is low
//   rxd_i      : serial input, idle high
//   txd_o      : serial output, idle high
//   overrun_o  : sticky received-byte-dropped flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_responder
    import uart_bus_responder_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_bus_responder_if.slave  bus,
    inout  wire [7:0]            data_io,
    input  wire logic            rxd_i,
    output logic                 txd_o,
    output logic                 overrun_o
);
    localparam int               DIV        = CLK_HZ / BAUD;
    localparam int               CNT_W      = cnt_width(DIV);
    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(DIV - 1);

    // Write strobe synchronizer and capture register.
    logic       wrn_s1_q, wrn_s2_q, wrn_prev_q;
    uart_byte_t cap_q;

    // Transmitter.
    uart_state_e      tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    uart_byte_t       tx_shift_q;
    uart_byte_t       thr_q;
    logic             tbre_q;
    logic             tsre_q;
    logic             txd_q;

    uart_byte_t w_rx_buf;
    logic       w_data_ready;
    logic       w_wrn_rise;
    logic       w_tx_last;
    logic       w_tx_load;
    logic       w_wr_accept;

    // Bus read is purely combinational on the raw strobe.
    assign data_io = bus.rdn ? 8'bz : w_rx_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrn_s1_q   <= 1'b1;
            wrn_s2_q   <= 1'b1;
            wrn_prev_q <= 1'b1;
            cap_q      <= '0;
        end else begin
            wrn_s1_q   <= bus.wrn;
            wrn_s2_q   <= wrn_s1_q;
            wrn_prev_q <= wrn_s2_q;
            if (!wrn_s2_q) begin
                cap_q <= data_io;
            end
        end
    end

    assign w_wrn_rise = wrn_s2_q & ~wrn_prev_q;
    assign w_tx_last  = (tx_cnt_q == c_DIV_LAST);
    // The shifter takes thr when idle or at the very end of a stop bit.
    assign w_tx_load  = !tbre_q &&
                        ((tx_state_q == ST_IDLE) ||
                         ((tx_state_q == ST_STOP) && w_tx_last));
    // A write is taken when thr is empty or is being emptied this cycle.
    assign w_wr_accept = w_wrn_rise && (tbre_q || w_tx_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            thr_q      <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    if (w_tx_load) begin
                        tx_shift_q <= thr_q;
                        tbre_q     <= 1'b1;
                        tsre_q     <= 1'b0;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tx_last) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                        tx_state_q <= ST_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tx_last) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == c_LAST_BIT) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= ST_STOP;
                        end else begin
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            txd_q      <= tx_shift_q[1];
                            tx_bit_q   <= tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tx_last) begin
                        tx_cnt_q <= '0;
                        if (w_tx_load) begin
                            // Back-to-back: next start bit follows immediately.
                            tx_shift_q <= thr_q;
                            tbre_q     <= 1'b1;
                            txd_q      <= 1'b0;
                            tx_state_q <= ST_START;
                        end else begin
                            tsre_q     <= 1'b1;
                            tx_state_q <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase

            // Placed after the FSM so a write coinciding with a reload wins
            // on tbre while the reload has already taken the old thr.
            if (w_wr_accept) begin
                thr_q  <= cap_q;
                tbre_q <= 1'b0;
            end
        end
    end

    uart_bus_responder_rx_core #(
        .DIV (DIV)
    ) u_rx_core (
        .clk          (clk),
        .rst          (rst),
        .rxd_i        (rxd_i),
        .rdn_i        (bus.rdn),
        .rx_buf_o     (w_rx_buf),
        .data_ready_o (w_data_ready),
        .overrun_o    (overrun_o)
    );

    assign bus.data_ready = w_data_ready;
    assign bus.tbre       = tbre_q;
    assign bus.tsre       = tsre_q;
    assign txd_o          = txd_q;

endmodule
`default_nettype wire
